uart_rx_fsm: RTL and testbench

UART_RX_FSM -- requirements
Module: uart_rx_fsm

---
 rtl/uart_rx_pkg.sv | 22 ++
 rtl/edge_bit_counter.sv | 35 +++
 rtl/uart_rx_fsm.sv | 122 ++++++++++++
 tb/tb_uart_rx_fsm.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared state encoding, counter widths and check-point helper for the UART receiver
package uart_rx_pkg;

  localparam int EDGE_W = 6;
  localparam int BIT_W  = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  localparam logic [BIT_W-1:0] LAST_DATA_BIT = 4'd8;

  // Two samples past mid-bit, so the 3-sample majority vote has settled.
  function automatic logic [EDGE_W-1:0] check_point(input logic [EDGE_W-1:0] ratio);
    return (ratio >> 1) + EDGE_W'(2);
  endfunction

endpackage

// File: rtl/edge_bit_counter.sv
// rtl/edge_bit_counter.sv - oversampling edge counter and bit position counter for one frame
module edge_bit_counter
  import uart_rx_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              clear,
  input  logic [EDGE_W-1:0] prescale,
  output logic [EDGE_W-1:0] edge_cnt,
  output logic [BIT_W-1:0]  bit_cnt
);

  logic bit_end;

  assign bit_end = (edge_cnt == prescale - EDGE_W'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (clear) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (enable) begin
      if (bit_end) begin
        edge_cnt <= '0;
        bit_cnt  <= bit_cnt + BIT_W'(1);
      end else begin
        edge_cnt <= edge_cnt + EDGE_W'(1);
      end
    end
  end

endmodule

// File: rtl/uart_rx_fsm.sv
// rtl/uart_rx_fsm.sv - UART receive sequencer: frame state, stage enables and frame-accept pulse
module uart_rx_fsm
  import uart_rx_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_in,
  input  logic              par_en,
  input  logic [EDGE_W-1:0] prescale,
  input  logic              strt_glitch,
  input  logic              par_err,
  input  logic              stp_err,
  output logic              dat_samp_en,
  output logic              strt_chk_en,
  output logic              par_chk_en,
  output logic              stp_chk_en,
  output logic              deser_en,
  output logic [EDGE_W-1:0] edge_cnt,
  output logic [BIT_W-1:0]  bit_cnt,
  output logic              data_valid
);

  rx_state_t state;
  logic      rx_last;
  logic      frame_par;
  logic      last_edge;
  logic      pre_chk;
  logic      cnt_enable;
  logic      cnt_clear;

  assign last_edge = (edge_cnt == prescale - EDGE_W'(1));
  // Enables are registered, so they are armed one edge before the check point.
  assign pre_chk   = (edge_cnt == check_point(prescale) - EDGE_W'(1));

  assign cnt_enable = (state != IDLE);
  assign cnt_clear  = (state == IDLE) ||
                      (last_edge && ((state == START  && strt_glitch) ||
                                     (state == PARITY && par_err)     ||
                                     (state == STOP)));

  edge_bit_counter u_counter (
    .clk      (clk),
    .rst      (rst),
    .enable   (cnt_enable),
    .clear    (cnt_clear),
    .prescale (prescale),
    .edge_cnt (edge_cnt),
    .bit_cnt  (bit_cnt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      rx_last     <= 1'b0;
      frame_par   <= 1'b0;
      dat_samp_en <= 1'b0;
      strt_chk_en <= 1'b0;
      deser_en    <= 1'b0;
      par_chk_en  <= 1'b0;
      stp_chk_en  <= 1'b0;
      data_valid  <= 1'b0;
    end else begin
      rx_last     <= rx_in;
      strt_chk_en <= (state == START)  && pre_chk;
      deser_en    <= (state == DATA)   && pre_chk;
      par_chk_en  <= (state == PARITY) && pre_chk;
      stp_chk_en  <= (state == STOP)   && pre_chk;
      data_valid  <= (state == STOP)   && last_edge && !stp_err;

      case (state)
        IDLE: begin
          // rx_last resets low, so a line held low through reset is not a start.
          if (rx_last && !rx_in) begin
            state       <= START;
            dat_samp_en <= 1'b1;
          end
        end
        START: begin
          if (last_edge) begin
            if (strt_glitch) begin
              state       <= IDLE;
              dat_samp_en <= 1'b0;
            end else begin
              state     <= DATA;
              frame_par <= par_en;
            end
          end
        end
        DATA: begin
          if (last_edge && bit_cnt == LAST_DATA_BIT) begin
            state <= frame_par ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (last_edge) begin
            if (par_err) begin
              state       <= IDLE;
              dat_samp_en <= 1'b0;
            end else begin
              state <= STOP;
            end
          end
        end
        STOP: begin
          if (last_edge) begin
            if (!rx_in) begin
              state <= START;
            end else begin
              state       <= IDLE;
              dat_samp_en <= 1'b0;
            end
          end
        end
        default: begin
          state       <= IDLE;
          dat_samp_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// tb/tb_uart_rx_fsm.sv - scoreboard bench for uart_rx_fsm against a frame-level timing model
module tb_uart_rx_fsm;

  logic       clk         = 1'b0;
  logic       rst         = 1'b0;
  logic       rx_in       = 1'b0;
  logic       par_en      = 1'b0;
  logic [5:0] prescale    = 6'd8;
  logic       strt_glitch = 1'b0;
  logic       par_err     = 1'b0;
  logic       stp_err     = 1'b0;
  logic       dat_samp_en, strt_chk_en, par_chk_en, stp_chk_en, deser_en, data_valid;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;

  typedef struct {
    int kind;
    int cyc;
    int ecnt;
    int bcnt;
  } ev_t;

  ev_t   exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc    = 0;
  string kind_name [5] = '{"strt_chk_en", "deser_en", "par_chk_en", "stp_chk_en", "data_valid"};

  uart_rx_fsm dut (
    .clk         (clk),
    .rst         (rst),
    .rx_in       (rx_in),
    .par_en      (par_en),
    .prescale    (prescale),
    .strt_glitch (strt_glitch),
    .par_err     (par_err),
    .stp_err     (stp_err),
    .dat_samp_en (dat_samp_en),
    .strt_chk_en (strt_chk_en),
    .par_chk_en  (par_chk_en),
    .stp_chk_en  (stp_chk_en),
    .deser_en    (deser_en),
    .edge_cnt    (edge_cnt),
    .bit_cnt     (bit_cnt),
    .data_valid  (data_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, want);
    end
  endtask

  task automatic push_ev(input int kind, input int c, input int e, input int b, input int lim);
    if (c < lim) exp_q.push_back(ev_t'{kind, c, e, b});
  endtask

  task automatic score(input int k);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_%s: got pulse at cycle %0d expected none", kind_name[k], cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.cyc != cyc || e.ecnt != int'(edge_cnt) || e.bcnt != int'(bit_cnt)) begin
        errors++;
        $display("FAIL event: got %s cyc=%0d edge=%0d bit=%0d expected %s cyc=%0d edge=%0d bit=%0d",
                 kind_name[k], cyc, edge_cnt, bit_cnt, kind_name[e.kind], e.cyc, e.ecnt, e.bcnt);
      end
    end
  endtask

  // Monitor: every pulse on an enable or data_valid is matched against the model queue.
  initial begin
    logic [4:0] hits;
    forever begin
      @(negedge clk);
      hits = {data_valid, stp_chk_en, par_chk_en, deser_en, strt_chk_en};
      if (rst && hits != 5'b0) begin
        if (hits[3:0] != 4'b0) begin
          checks++;
          if ($countones(hits[3:0]) > 1) begin
            errors++;
            $display("FAIL enable_onehot: got %b expected at most one bit set", hits[3:0]);
          end
        end
        for (int k = 0; k < 5; k++) if (hits[k]) score(k);
      end
    end
  end

  function automatic logic line_bit(input int k, input logic [7:0] d, input bit pe);
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
    if (k == 9 && pe) return ^d;
    return 1'b1;
  endfunction

  task automatic idle_gap(input int n);
    rx_in = 1'b1;
    repeat (n) @(negedge clk);
    check("idle_dat_samp_en", dat_samp_en, 0);
    check("idle_edge_cnt", edge_cnt, 0);
    check("idle_bit_cnt", bit_cnt, 0);
  endtask

  // Must be entered just after a negedge; the start bit is sampled on the next posedge.
  task automatic send_frame(input int p, input bit pe, input logic [7:0] d, input bit glitch,
                            input bit perr, input bit serr, input int abort_at);
    int n, chk, nb, len, lim, b;
    n   = cyc + 1;
    chk = p / 2 + 2;
    nb  = pe ? 11 : 10;
    lim = (abort_at < 0) ? 32'h7fffffff : n + abort_at;
    len = glitch ? p : nb * p;
    push_ev(0, n + chk, chk, 0, lim);
    if (!glitch) begin
      for (int k = 1; k <= 8; k++) push_ev(1, n + k * p + chk, chk, k, lim);
      b = 9;
      if (pe) begin
        push_ev(2, n + 9 * p + chk, chk, 9, lim);
        b = 10;
      end
      if (!(pe && perr)) begin
        push_ev(3, n + b * p + chk, chk, b, lim);
        if (!serr) push_ev(4, n + (b + 1) * p, 0, 0, lim);
      end
    end
    for (int i = 0; i < len; i++) begin
      if (i == abort_at) begin
        check("pre_rst_edge_cnt", edge_cnt, (abort_at - 1) % p);
        check("pre_rst_bit_cnt", bit_cnt, (abort_at - 1) / p);
        #2 rst = 1'b0;
        #1;
        check("rst_enables", {dat_samp_en, strt_chk_en, deser_en, par_chk_en, stp_chk_en, data_valid}, 0);
        check("rst_edge_cnt", edge_cnt, 0);
        check("rst_bit_cnt", bit_cnt, 0);
        rx_in = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        return;
      end
      if (i == p / 2) check("busy_dat_samp_en", dat_samp_en, 1);
      if (i == 1) begin
        prescale    = 6'(p);
        par_en      = pe;
        strt_glitch = glitch;
        par_err     = perr;
        stp_err     = serr;
      end
      if (i == p + 2) par_en = 1'($urandom_range(0, 1));
      rx_in = glitch ? ((i < 3) ? 1'b0 : 1'b1) : line_bit(i / p, d, pe);
      @(negedge clk);
    end
  endtask

  initial begin
    int  p, plist [3];
    bit  pe, glitch, perr, serr, b2b, done;
    logic [7:0] d;
    plist = '{8, 16, 32};

    repeat (2) @(negedge clk);
    check("reset_dat_samp_en", dat_samp_en, 0);
    check("reset_enables", {strt_chk_en, deser_en, par_chk_en, stp_chk_en, data_valid}, 0);
    check("reset_edge_cnt", edge_cnt, 0);
    check("reset_bit_cnt", bit_cnt, 0);

    // Line already low at release: no frame until a fresh falling edge.
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("low_after_reset_idle", dat_samp_en, 0);
    idle_gap(3);

    send_frame(8, 1'b0, 8'h55, 1'b0, 1'b0, 1'b0, -1);
    idle_gap(3);
    send_frame(16, 1'b1, 8'hA3, 1'b0, 1'b0, 1'b0, -1);
    idle_gap(3);
    send_frame(8, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, -1);
    idle_gap(3);
    send_frame(32, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, -1);
    idle_gap(3);
    send_frame(16, 1'b0, 8'h96, 1'b0, 1'b0, 1'b0, -1);
    send_frame(16, 1'b0, 8'h69, 1'b0, 1'b0, 1'b0, -1);
    idle_gap(3);
    send_frame(8, 1'b0, 8'hF0, 1'b0, 1'b0, 1'b0, 4 * 8 + 1);
    idle_gap(3);
    send_frame(8, 1'b1, 8'h81, 1'b0, 1'b0, 1'b0, -1);
    idle_gap(3);

    p = 8;
    for (int f = 0; f < 30; f++) begin
      pe     = 1'($urandom_range(0, 1));
      d      = 8'($urandom);
      glitch = ($urandom_range(0, 7) == 0);
      perr   = pe && ($urandom_range(0, 3) == 0);
      serr   = ($urandom_range(0, 3) == 0);
      send_frame(p, pe, d, glitch, perr, serr, -1);
      done = !glitch && !perr;
      b2b  = done && ($urandom_range(0, 2) == 0);
      if (!b2b) begin
        idle_gap($urandom_range(2, 6));
        p = plist[$urandom_range(0, 2)];
      end
    end

    idle_gap(10);
    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
